control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 start  input  1  level-sampled; starts program execution from address 0 when the block is in IDLE.
REQ-005 pc  output  8  instruction memory address.
REQ-006 ir_rd  output  1  instruction read strobe; memory returns ir_data exactly one cycle later.
REQ-007 ir_data  input  16  instruction word: [15:12] opcode, [11:9] dst, [8:6] srcA, [5:3] srcB, [7:0] branch target.
REQ-008 alu_op  output  4  ALU control code driven to the datapath ALU.
REQ-009 a_sel  output  3  register file index driven onto the A bus.
REQ-010 b_sel  output  3  register file index driven onto the B bus.
REQ-011 c_wr  output  1  register file write enable for the C bus.
REQ-012 c_dst  output  3  register file write index.
REQ-013 z_flag  input  1  high when the C bus equals 16'h0000 in the current cycle.
REQ-014 busy  output  1  high in FETCH, DECODE and EXEC.
REQ-015 halted  output  1  high in HALT.

Function
REQ-016 The FSM SHALL have exactly five states: IDLE, FETCH, DECODE, EXEC, HALT.
REQ-017 IDLE -> FETCH when start=1, loading pc=8'h00. start SHALL be ignored in every other state.
REQ-018 FETCH: ir_rd=1 for one cycle at the current pc, then go to DECODE.
REQ-019 DECODE: latch ir_data into an internal 16-bit IR, then go to EXEC.
REQ-020 EXEC: drive alu_op, a_sel=IR[8:6], b_sel=IR[5:3] and c_dst=IR[11:9] combinationally from IR for exactly one cycle.
REQ-021 Each non-branch instruction SHALL take exactly 3 cycles (FETCH, DECODE, EXEC) and then return to FETCH with pc+1.
REQ-022 pc SHALL wrap from 8'hFF to 8'h00 without any error indication.
REQ-023 Opcodes 0x1-0xC SHALL set alu_op equal to the opcode in EXEC: 1 CLR, 2 PASSA, 3 PASSB, 4 ADD, 5 SUB, 6 A>>2, 7 A>>1, 8 A-1, 9 B-1, A A+1, B B<<8, C A<<8. They SHALL also set c_wr=1.
REQ-024 Opcode 0x0 (NOP) SHALL set alu_op=4'b0000 and c_wr=0 in EXEC.
REQ-025 Opcode 0xD (JNZ): in EXEC set alu_op=4'b0010 and c_wr=0, then sample z_flag.
REQ-026 JNZ target selection: z_flag=0 -> pc<=IR[7:0]; z_flag=1 -> pc<=pc+1.
REQ-027 Opcode 0xE (JMP): in EXEC set alu_op=4'b0000 and c_wr=0, then pc<=IR[7:0].
REQ-028 Opcode 0xF (HALT): in EXEC set c_wr=0, then go to HALT with pc unchanged.
REQ-029 HALT SHALL be left only by reset; start is ignored while in HALT.
REQ-030 Outside EXEC, outputs SHALL be alu_op=4'b0000, c_wr=0, a_sel=0, b_sel=0, c_dst=0.
REQ-031 ir_rd SHALL be high only in FETCH.
REQ-032 A branch whose target equals its own pc SHALL loop indefinitely and SHALL NOT be detected as an error.

Reset
REQ-033 When reset=1 at a clock edge, the block SHALL enter IDLE from any state, including mid-instruction.
REQ-034 Reset SHALL force pc=0, IR=0, ir_rd=0, alu_op=0, a_sel=0, b_sel=0, c_wr=0, c_dst=0, busy=0, halted=0.
REQ-035 reset SHALL take priority over start in the same cycle.
REQ-036 No partial write SHALL occur after reset: c_wr=0 in the cycle following a reset edge.

Verification
REQ-037 ADD, single instruction: mem[0]=16'h4A98 (ADD dst5,srcA2,srcB3), pulse start.
  -> ir_rd=1 at pc=0 one cycle after start.
  -> EXEC two cycles later: alu_op=0100, a_sel=2, b_sel=3, c_dst=5, c_wr=1.
  -> next cycle: FETCH at pc=1.
REQ-038 JNZ both ways: mem[0]=16'hD03C (JNZ srcA0, target 8'h3C).
  -> z_flag=0 in EXEC: next FETCH pc=8'h3C.
  -> rerun with z_flag=1: next FETCH pc=8'h01.
REQ-039 HALT: mem[0]=16'hF000.
  -> after EXEC: halted=1, busy=0, ir_rd=0.
  -> start=1 for 10 cycles: no change.
  -> reset: IDLE, halted=0.
REQ-040 PC wrap: JMP 8'hFF, then a NOP at 8'hFF.
  -> next FETCH pc=8'h00.
REQ-041 Reset mid-EXEC of ADD: assert reset in the EXEC cycle.
  -> next cycle: all outputs zero, IDLE, no c_wr pulse.
  -> same cycle start=1 with reset=1: stays IDLE.
REQ-042 Every opcode 0x0-0xF: EXEC-cycle alu_op and c_wr SHALL match REQ-023 to REQ-028.

Source files
------------

// File: rtl/control_sequencer.sv
// control_sequencer: five-state microsequencer (IDLE/FETCH/DECODE/EXEC/HALT).
// It fetches 16-bit instructions, decodes them and drives ALU/register-file
// control for one EXEC cycle per instruction. JNZ/JMP redirect the pc, and
// HALT parks the block until reset.
// Handshake: ir_rd is a one-cycle read strobe raised in FETCH. The memory
// presents ir_data on the following cycle (DECODE), and the instruction
// is captured on the DECODE->EXEC edge. No back-pressure exists.
module control_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [7:0]  pc,
  output logic        ir_rd,
  input  logic [15:0] ir_data,
  output logic [3:0]  alu_op,
  output logic [2:0]  a_sel,
  output logic [2:0]  b_sel,
  output logic        c_wr,
  output logic [2:0]  c_dst,
  input  logic        z_flag,
  output logic        busy,
  output logic        halted,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_JNZ  = 4'hD;
  localparam logic [3:0] OP_JMP  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t      state_q;
  logic [7:0]  pc_q;
  logic [15:0] ir_q;
  logic        ir_rd_q;
  logic [3:0]  alu_op_q;
  logic [2:0]  a_sel_q;
  logic [2:0]  b_sel_q;
  logic        c_wr_q;
  logic [2:0]  c_dst_q;
  logic        busy_q;
  logic        halted_q;

  logic [3:0]  alu_op_d;
  logic        c_wr_d;
  logic [7:0]  pc_inc_d;

  // Decode the incoming word so EXEC-cycle controls can be registered on DECODE->EXEC.
  always_comb begin
    alu_op_d = 4'h0;
    c_wr_d   = 1'b0;
    case (ir_data[15:12])
      OP_NOP:  begin alu_op_d = 4'h0; c_wr_d = 1'b0; end
      OP_JNZ:  begin alu_op_d = 4'h2; c_wr_d = 1'b0; end
      OP_JMP:  begin alu_op_d = 4'h0; c_wr_d = 1'b0; end
      OP_HALT: begin alu_op_d = 4'h0; c_wr_d = 1'b0; end
      default: begin alu_op_d = ir_data[15:12]; c_wr_d = 1'b1; end
    endcase
    pc_inc_d = pc_q + 8'd1;
  end

  // Sequencer FSM with all outputs registered; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pc_q     <= 8'h00;
      ir_q     <= 16'h0000;
      ir_rd_q  <= 1'b0;
      alu_op_q <= 4'h0;
      a_sel_q  <= 3'd0;
      b_sel_q  <= 3'd0;
      c_wr_q   <= 1'b0;
      c_dst_q  <= 3'd0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_FETCH;
            pc_q    <= 8'h00;
            ir_rd_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_FETCH: begin
          ir_rd_q <= 1'b0;
          state_q <= S_DECODE;
        end
        S_DECODE: begin
          ir_q     <= ir_data;
          alu_op_q <= alu_op_d;
          a_sel_q  <= ir_data[8:6];
          b_sel_q  <= ir_data[5:3];
          c_dst_q  <= ir_data[11:9];
          c_wr_q   <= c_wr_d;
          state_q  <= S_EXEC;
        end
        S_EXEC: begin
          alu_op_q <= 4'h0;
          a_sel_q  <= 3'd0;
          b_sel_q  <= 3'd0;
          c_dst_q  <= 3'd0;
          c_wr_q   <= 1'b0;
          if (ir_q[15:12] == OP_HALT) begin
            state_q  <= S_HALT;
            busy_q   <= 1'b0;
            halted_q <= 1'b1;
          end else begin
            state_q <= S_FETCH;
            ir_rd_q <= 1'b1;
            case (ir_q[15:12])
              OP_JNZ:  pc_q <= z_flag ? pc_inc_d : ir_q[7:0];
              OP_JMP:  pc_q <= ir_q[7:0];
              default: pc_q <= pc_inc_d;
            endcase
          end
        end
        S_HALT: begin
          state_q <= S_HALT;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign pc        = pc_q;
  assign ir_rd     = ir_rd_q;
  assign alu_op    = alu_op_q;
  assign a_sel     = a_sel_q;
  assign b_sel     = b_sel_q;
  assign c_wr      = c_wr_q;
  assign c_dst     = c_dst_q;
  assign busy      = busy_q;
  assign halted    = halted_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed testbench for control_sequencer with a one-cycle-latency instruction memory.
module tb_control_sequencer;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_HALT   = 3'd4;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  pc;
  logic        ir_rd;
  logic [15:0] ir_data;
  logic [3:0]  alu_op;
  logic [2:0]  a_sel;
  logic [2:0]  b_sel;
  logic        c_wr;
  logic [2:0]  c_dst;
  logic        z_flag;
  logic        busy;
  logic        halted;
  logic [2:0]  dbg_state;

  logic [15:0] mem [256];
  int checks;
  int failures;

  control_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .pc(pc), .ir_rd(ir_rd),
    .ir_data(ir_data), .alu_op(alu_op), .a_sel(a_sel), .b_sel(b_sel),
    .c_wr(c_wr), .c_dst(c_dst), .z_flag(z_flag), .busy(busy),
    .halted(halted), .dbg_state(dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // instruction memory: data returned one cycle after the read strobe
  initial ir_data = 16'h0000;
  always @(posedge clk) begin
    if (ir_rd) ir_data <= mem[pc];
  end

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset  = 1'b1;
    start  = 1'b0;
    z_flag = 1'b0;
    @(negedge clk);
    reset  = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({pc, ir_rd, alu_op, a_sel, b_sel, c_wr, c_dst, busy, halted} !== 27'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=0", {pc, ir_rd, alu_op, a_sel, b_sel, c_wr, c_dst, busy, halted});
    end
    checks++;
    if (dbg_state !== ST_IDLE) begin
      failures++;
      $display("FAIL reset_state got=%0d want=%0d", dbg_state, ST_IDLE);
    end
    // start stays low: must remain idle
    @(negedge clk);
    checks++;
    if (dbg_state !== ST_IDLE || busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_hold state=%0d busy=%b want state=0 busy=0", dbg_state, busy);
    end
  endtask

  task automatic test_add();
    clear_mem();
    mem[0] = 16'h4A98;
    do_reset();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (ir_rd !== 1'b1 || pc !== 8'h00 || busy !== 1'b1) begin
      failures++;
      $display("FAIL add_fetch ir_rd=%b pc=%h busy=%b want 1 00 1", ir_rd, pc, busy);
    end
    @(negedge clk);
    checks++;
    if (dbg_state !== ST_DECODE || ir_rd !== 1'b0 || c_wr !== 1'b0 || alu_op !== 4'h0) begin
      failures++;
      $display("FAIL add_decode state=%0d ir_rd=%b c_wr=%b alu_op=%h want 2 0 0 0", dbg_state, ir_rd, c_wr, alu_op);
    end
    @(negedge clk);
    checks++;
    if (alu_op !== 4'b0100 || a_sel !== 3'd2 || b_sel !== 3'd3 || c_dst !== 3'd5 || c_wr !== 1'b1) begin
      failures++;
      $display("FAIL add_exec alu=%h a=%0d b=%0d dst=%0d wr=%b want 4 2 3 5 1", alu_op, a_sel, b_sel, c_dst, c_wr);
    end
    @(negedge clk);
    checks++;
    if (ir_rd !== 1'b1 || pc !== 8'h01 || c_wr !== 1'b0 || alu_op !== 4'h0 || a_sel !== 3'd0 || b_sel !== 3'd0 || c_dst !== 3'd0) begin
      failures++;
      $display("FAIL add_next_fetch ir_rd=%b pc=%h wr=%b alu=%h want 1 01 0 0", ir_rd, pc, c_wr, alu_op);
    end
  endtask

  task automatic test_jnz();
    logic [7:0] exp_pc;
    for (int z = 0; z < 2; z++) begin
      clear_mem();
      mem[0] = 16'hD03C;
      do_reset();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      z_flag = z[0];
      checks++;
      if (alu_op !== 4'b0010 || c_wr !== 1'b0) begin
        failures++;
        $display("FAIL jnz_exec z=%0d alu=%h wr=%b want 2 0", z, alu_op, c_wr);
      end
      @(negedge clk);
      z_flag = 1'b0;
      exp_pc = (z == 0) ? 8'h3C : 8'h01;
      checks++;
      if (pc !== exp_pc || ir_rd !== 1'b1) begin
        failures++;
        $display("FAIL jnz_target z=%0d pc=%h ir_rd=%b want %h 1", z, pc, ir_rd, exp_pc);
      end
    end
  endtask

  task automatic test_halt();
    clear_mem();
    mem[0] = 16'hF000;
    do_reset();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (c_wr !== 1'b0) begin
      failures++;
      $display("FAIL halt_exec_wr got=%b want 0", c_wr);
    end
    @(negedge clk);
    checks++;
    if (halted !== 1'b1 || busy !== 1'b0 || ir_rd !== 1'b0 || pc !== 8'h00 || dbg_state !== ST_HALT) begin
      failures++;
      $display("FAIL halt_enter halted=%b busy=%b ir_rd=%b pc=%h st=%0d want 1 0 0 00 4", halted, busy, ir_rd, pc, dbg_state);
    end
    start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (halted !== 1'b1 || busy !== 1'b0 || ir_rd !== 1'b0 || pc !== 8'h00 || dbg_state !== ST_HALT) begin
        failures++;
        $display("FAIL halt_hold cyc=%0d halted=%b busy=%b ir_rd=%b pc=%h want 1 0 0 00", i, halted, busy, ir_rd, pc);
      end
    end
    do_reset();
    checks++;
    if (halted !== 1'b0 || dbg_state !== ST_IDLE) begin
      failures++;
      $display("FAIL halt_reset halted=%b st=%0d want 0 0", halted, dbg_state);
    end
  endtask

  task automatic test_pc_wrap();
    clear_mem();
    mem[0]   = 16'hE0FF;
    mem[255] = 16'h0000;
    do_reset();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (pc !== 8'hFF || ir_rd !== 1'b1) begin
      failures++;
      $display("FAIL wrap_jmp pc=%h ir_rd=%b want ff 1", pc, ir_rd);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (alu_op !== 4'h0 || c_wr !== 1'b0) begin
      failures++;
      $display("FAIL wrap_nop alu=%h wr=%b want 0 0", alu_op, c_wr);
    end
    @(negedge clk);
    checks++;
    if (pc !== 8'h00 || ir_rd !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL wrap_pc pc=%h ir_rd=%b busy=%b want 00 1 1", pc, ir_rd, busy);
    end
  endtask

  task automatic test_reset_mid_exec();
    clear_mem();
    mem[0] = 16'h4A98;
    do_reset();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    checks++;
    if ({pc, ir_rd, alu_op, a_sel, b_sel, c_wr, c_dst, busy, halted} !== 27'd0 || dbg_state !== ST_IDLE) begin
      failures++;
      $display("FAIL midexec_reset outs=%h st=%0d want 0 0", {pc, ir_rd, alu_op, a_sel, b_sel, c_wr, c_dst, busy, halted}, dbg_state);
    end
    @(negedge clk);
    checks++;
    if (dbg_state !== ST_IDLE || busy !== 1'b0 || ir_rd !== 1'b0) begin
      failures++;
      $display("FAIL reset_over_start st=%0d busy=%b ir_rd=%b want 0 0 0", dbg_state, busy, ir_rd);
    end
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (dbg_state !== ST_IDLE || c_wr !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_idle st=%0d wr=%b want 0 0", dbg_state, c_wr);
    end
  endtask

  task automatic test_all_opcodes();
    logic [3:0] exp_alu;
    logic       exp_wr;
    logic [7:0] exp_pc;
    logic [2:0] exp_st;
    for (int op = 0; op < 16; op++) begin
      clear_mem();
      mem[0] = {op[3:0], 12'hA98};
      if (op >= 1 && op <= 12) begin exp_alu = op[3:0]; exp_wr = 1'b1; end
      else if (op == 13)       begin exp_alu = 4'h2;    exp_wr = 1'b0; end
      else                     begin exp_alu = 4'h0;    exp_wr = 1'b0; end
      if (op == 15)            begin exp_pc = 8'h00; exp_st = ST_HALT; end
      else if (op == 13 || op == 14) begin exp_pc = 8'h98; exp_st = ST_FETCH; end
      else                     begin exp_pc = 8'h01; exp_st = ST_FETCH; end
      do_reset();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (c_wr !== exp_wr || a_sel !== 3'd2 || b_sel !== 3'd3 || c_dst !== 3'd5 ||
          (op != 15 && alu_op !== exp_alu)) begin
        failures++;
        $display("FAIL opcode_exec op=%h alu=%h wr=%b a=%0d b=%0d dst=%0d want alu=%h wr=%b a=2 b=3 dst=5",
                 op, alu_op, c_wr, a_sel, b_sel, c_dst, exp_alu, exp_wr);
      end
      @(negedge clk);
      checks++;
      if (pc !== exp_pc || dbg_state !== exp_st || c_wr !== 1'b0) begin
        failures++;
        $display("FAIL opcode_next op=%h pc=%h st=%0d wr=%b want pc=%h st=%0d wr=0", op, pc, dbg_state, c_wr, exp_pc, exp_st);
      end
    end
  endtask

  task automatic test_back_to_back();
    // ADD at 0 then SUB at 1, then JMP to itself at 2 loops forever
    clear_mem();
    mem[0] = 16'h4A98;
    mem[1] = 16'h5C50;
    mem[2] = 16'hE002;
    do_reset();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    @(negedge clk);
    checks++;
    if (alu_op !== 4'h5 || c_wr !== 1'b1 || c_dst !== 3'd6 || a_sel !== 3'd1 || b_sel !== 3'd2) begin
      failures++;
      $display("FAIL b2b_sub alu=%h wr=%b dst=%0d a=%0d b=%0d want 5 1 6 1 2", alu_op, c_wr, c_dst, a_sel, b_sel);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (pc !== 8'h02 || ir_rd !== 1'b1 || busy !== 1'b1 || halted !== 1'b0) begin
        failures++;
        $display("FAIL self_loop iter=%0d pc=%h ir_rd=%b busy=%b halted=%b want 02 1 1 0", k, pc, ir_rd, busy, halted);
      end
      @(negedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    start    = 1'b0;
    z_flag   = 1'b0;
    clear_mem();
    test_reset();
    test_add();
    test_jnz();
    test_halt();
    test_pc_wrap();
    test_reset_mid_exec();
    test_all_opcodes();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
